// File: rtl/ibutterfly_pipe.sv
// Inverse radix-2 DIT butterfly: Yp = Xp + Xq*conj(W), Yq = Xp - Xq*conj(W), Q16.16.
// Latency 2 cycles; IBF_SCALE_EN selects the halved (bits [32:1]) output instead of wrap.
// Backpressure: both stages advance only when the output is empty or taken; in_ready = that enable.
module ibutterfly_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] xp_real,
  input  logic [31:0] xp_imag,
  input  logic [31:0] xq_real,
  input  logic [31:0] xq_imag,
  input  logic [31:0] wnr_real,
  input  logic [31:0] wnr_imag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] yp_real,
  output logic [31:0] yp_imag,
  output logic [31:0] yq_real,
  output logic [31:0] yq_imag,
  output logic        busy
);

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Operands widened to 65 bits so neither products nor their sums can overflow.
  logic signed [64:0] xqr_e, xqi_e, wr_e, wi_e;
  logic signed [64:0] t_re_sum, t_im_sum;
  assign xqr_e = {{33{xq_real[31]}}, xq_real};
  assign xqi_e = {{33{xq_imag[31]}}, xq_imag};
  assign wr_e  = {{33{wnr_real[31]}}, wnr_real};
  assign wi_e  = {{33{wnr_imag[31]}}, wnr_imag};

  // Multiplying by conj(W) flips the sign of the W imaginary terms.
  assign t_re_sum = xqr_e * wr_e + xqi_e * wi_e;
  assign t_im_sum = xqi_e * wr_e - xqr_e * wi_e;

  logic  s1_valid;
  cplx_t s1_xp, s1_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_xp    <= '0;
      s1_t     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_xp <= {xp_real, xp_imag};
        s1_t  <= {t_re_sum[47:16], t_im_sum[47:16]};
      end
    end
  end

  logic [32:0] sp_re, sp_im, sq_re, sq_im;
  assign sp_re = {s1_xp.re[31], s1_xp.re} + {s1_t.re[31], s1_t.re};
  assign sp_im = {s1_xp.im[31], s1_xp.im} + {s1_t.im[31], s1_t.im};
  assign sq_re = {s1_xp.re[31], s1_xp.re} - {s1_t.re[31], s1_t.re};
  assign sq_im = {s1_xp.im[31], s1_xp.im} - {s1_t.im[31], s1_t.im};

  cplx_t yp_next, yq_next;
  logic  unused_bits;
`ifdef IBF_SCALE_EN
  assign yp_next     = {sp_re[32:1], sp_im[32:1]};
  assign yq_next     = {sq_re[32:1], sq_im[32:1]};
  assign unused_bits = ^{t_re_sum[64:48], t_re_sum[15:0], t_im_sum[64:48], t_im_sum[15:0],
                         sp_re[0], sp_im[0], sq_re[0], sq_im[0]};
`else
  assign yp_next     = {sp_re[31:0], sp_im[31:0]};
  assign yq_next     = {sq_re[31:0], sq_im[31:0]};
  assign unused_bits = ^{t_re_sum[64:48], t_re_sum[15:0], t_im_sum[64:48], t_im_sum[15:0],
                         sp_re[32], sp_im[32], sq_re[32], sq_im[32]};
`endif

  cplx_t yp_q, yq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      yp_q      <= '0;
      yq_q      <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        yp_q <= yp_next;
        yq_q <= yq_next;
      end
    end
  end

  assign yp_real = yp_q.re;
  assign yp_imag = yp_q.im;
  assign yq_real = yq_q.re;
  assign yq_imag = yq_q.im;
  assign busy    = s1_valid || out_valid;

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Bench for ibutterfly_pipe: directed vectors, streaming, stalls, mid-run reset and random traffic
// against a scoreboard fed by an arithmetic reference model.
module tb_ibutterfly_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] xp_real = '0, xp_imag = '0, xq_real = '0, xq_imag = '0;
  logic [31:0] wnr_real = '0, wnr_imag = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] yp_real, yp_imag, yq_real, yq_imag;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] ypr;
    logic [31:0] ypi;
    logic [31:0] yqr;
    logic [31:0] yqi;
  } res_t;

  res_t sb_q[$];

  ibutterfly_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
    .wnr_real(wnr_real), .wnr_imag(wnr_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: exact complex arithmetic, t floored to Q16.16, then wrap or halve.
  function automatic res_t ref_bfly(input logic [31:0] pr, pi, qr, qi, wr, wi);
    logic signed [64:0] tr, ti, ypr, ypi, yqr, yqi;
    logic signed [31:0] t32r, t32i;
    res_t r;
    tr   = $signed(qr) * $signed(wr) + $signed(qi) * $signed(wi);
    ti   = $signed(qi) * $signed(wr) - $signed(qr) * $signed(wi);
    t32r = 32'(tr >>> 16);
    t32i = 32'(ti >>> 16);
    ypr  = $signed(pr) + t32r;
    ypi  = $signed(pi) + t32i;
    yqr  = $signed(pr) - t32r;
    yqi  = $signed(pi) - t32i;
`ifdef IBF_SCALE_EN
    r = {32'(ypr >>> 1), 32'(ypi >>> 1), 32'(yqr >>> 1), 32'(yqi >>> 1)};
`else
    r = {32'(ypr), 32'(ypi), 32'(yqr), 32'(yqi)};
`endif
    return r;
  endfunction

  // Scoreboard: samples between edges, predicts transfers at the coming rising edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      checks++;
      if (busy !== (sb_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_busy: busy=%b want %b (in flight %0d)", busy, (sb_q.size() != 0), sb_q.size());
      end
      if (out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: unexpected result %h", {yp_real, yp_imag, yq_real, yq_imag});
        end else if ({yp_real, yp_imag, yq_real, yq_imag} !== sb_q[0]) begin
          failures++;
          $display("FAIL sb_data: got %h want %h", {yp_real, yp_imag, yq_real, yq_imag}, sb_q[0]);
        end
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
      if (in_valid && in_ready)
        sb_q.push_back(ref_bfly(xp_real, xp_imag, xq_real, xq_imag, wnr_real, wnr_imag));
    end
  end

  task automatic set_inputs(input logic [31:0] pr, pi, qr, qi, wr, wi);
    xp_real = pr; xp_imag = pi; xq_real = qr; xq_imag = qi; wnr_real = wr; wnr_imag = wi;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL reset_ctrl: out_valid,busy,in_ready=%b want 001", {out_valid, busy, in_ready});
    end
    checks++;
    if ({yp_real, yp_imag, yq_real, yq_imag} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {yp_real, yp_imag, yq_real, yq_imag});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input string name, input logic [31:0] pr, pi, qr, qi, wr, wi,
                             input logic [31:0] epr, epi, eqr, eqi);
    @(negedge clk);
    set_inputs(pr, pi, qr, qi, wr, wi);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_lat1: out_valid=%b want 0", name, out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_lat2: out_valid=%b want 1", name, out_valid);
    end
    checks++;
    if ({yp_real, yp_imag, yq_real, yq_imag} !== {epr, epi, eqr, eqi}) begin
      failures++;
      $display("FAIL %s_data: got %h want %h", name, {yp_real, yp_imag, yq_real, yq_imag},
               {epr, epi, eqr, eqi});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] vpat;
    vpat = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1;
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      vpat[c] = out_valid;
    end
    checks++;
    if (vpat !== 8'b0011_1100) begin
      failures++;
      $display("FAIL b2b_pattern: out_valid by cycle=%b want 00111100", vpat);
    end
  endtask

  task automatic test_stall;
    logic [127:0] snap;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      if (i == 2) out_ready = 1'b0;
    end
    #1;
    snap = {yp_real, yp_imag, yq_real, yq_imag};
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL stall_enter: out_valid,in_ready=%b want 10", {out_valid, in_ready});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || {yp_real, yp_imag, yq_real, yq_imag} !== snap) begin
        failures++;
        $display("FAIL stall_hold%0d: out_valid=%b y=%h want 1 %h", k, out_valid,
                 {yp_real, yp_imag, yq_real, yq_imag}, snap);
      end
      checks++;
      if (in_ready !== (k == 2)) begin
        failures++;
        $display("FAIL stall_ready%0d: in_ready=%b want %b", k, in_ready, (k == 2));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain: pending=%0d busy=%b want 0 0", sb_q.size(), busy);
    end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL midrst_ctrl: out_valid,busy,in_ready=%b want 001", {out_valid, busy, in_ready});
    end
    checks++;
    if ({yp_real, yp_imag, yq_real, yq_imag} !== 128'h0) begin
      failures++;
      $display("FAIL midrst_data: got %h want 0", {yp_real, yp_imag, yq_real, yq_imag});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midrst_ghost%0d: out_valid=%b busy=%b want 0 0", k, out_valid, busy);
      end
    end
  endtask

  task automatic test_random;
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      end
      #1;
      hold = in_valid && !in_ready;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: %0d results never delivered", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef IBF_SCALE_EN
    test_vector("ones", 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0,
                32'h00010000, 0, 0, 0);
    test_vector("w_j", 32'h00010000, 0, 32'h00010000, 0, 0, 32'h00010000,
                32'h00008000, 32'hFFFF8000, 32'h00008000, 32'h00008000);
    test_vector("floor", 0, 0, 32'hFFFFFFFF, 0, 32'h00008000, 0,
                32'hFFFFFFFF, 0, 0, 0);
    test_vector("nowrap", 32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0,
                32'h7FFF0000, 0, 0, 0);
`else
    test_vector("ones", 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0,
                32'h00020000, 0, 0, 0);
    test_vector("w_j", 32'h00010000, 0, 32'h00010000, 0, 0, 32'h00010000,
                32'h00010000, 32'hFFFF0000, 32'h00010000, 32'h00010000);
    test_vector("floor", 0, 0, 32'hFFFFFFFF, 0, 32'h00008000, 0,
                32'hFFFFFFFF, 0, 32'h00000001, 0);
    test_vector("wrap", 32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0,
                32'hFFFE0000, 0, 0, 0);
`endif
    test_back_to_back();
    test_stall();
    test_mid_reset();
`ifdef IBF_SCALE_EN
    test_vector("post_rst", 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0,
                32'h00010000, 0, 0, 0);
`else
    test_vector("post_rst", 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0,
                32'h00020000, 0, 0, 0);
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibutterfly_pipe.md
IBUTTERFLY_PIPE -- requirements
Module: ibutterfly_pipe

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset; all other ports are listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand set present.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 xp_real, xp_imag, xq_real, xq_imag  input  32 each  signed Q16.16 operands Xm(p), Xm(q).
REQ-007 wnr_real, wnr_imag  input  32 each  signed Q16.16 forward twiddle W; the block applies conj(W) internally.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 yp_real, yp_imag, yq_real, yq_imag  output  32 each  signed Q16.16 results.
REQ-011 busy  output  1  high while either pipeline stage holds valid data.

Function
REQ-012 The block SHALL compute the inverse (DIT) butterfly: t = Xq*conj(W); Yp = Xp + t; Yq = Xp - t.
REQ-013 t_real = xq_real*wnr_real + xq_imag*wnr_imag, and t_imag = xq_imag*wnr_real - xq_real*wnr_imag; each product and sum SHALL be formed at full 65-bit signed width.
REQ-014 t SHALL be taken as bits [47:16] of each 65-bit sum: truncation toward minus infinity, with no rounding and no saturation.
REQ-015 The Yp/Yq adds and subtracts SHALL be formed at 33 bits; the unscaled result SHALL keep bits [31:0], so overflow wraps modulo 2^32.
REQ-016 The pipeline SHALL have two stages: stage 1 registers Xp and t; stage 2 registers the Y outputs.
REQ-017 Latency SHALL be exactly 2 clk cycles from an accept (in_valid and in_ready both high) to out_valid, when no stall occurs.
REQ-018 Define en = !out_valid || out_ready; both stages SHALL advance only when en is high, and in_ready SHALL equal en.
REQ-019 A stage with no valid input when advancing SHALL load a bubble: its valid bit clears and its data is don't-care.
REQ-020 While out_valid is high and out_ready is low, all Y outputs and out_valid SHALL hold stable, and stage 1 SHALL hold its contents.
REQ-021 Operands offered while in_ready is low SHALL be ignored and SHALL be re-offered by the source.
REQ-022 Simultaneous accept and output transfer SHALL sustain one result per cycle; back-to-back throughput SHALL be 1 per clk.
REQ-023 Operand order SHALL be preserved; no result is dropped or duplicated.
REQ-024 busy SHALL equal s1_valid OR s2_valid.

Reset
REQ-025 While rst_n is low: out_valid = 0, busy = 0, all Y outputs = 0, and both stage valid bits = 0.
REQ-026 in_ready SHALL be 1 during reset, since out_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands with no partial output.
REQ-028 The first accept after reset deassertion SHALL produce out_valid exactly 2 cycles later.

Configuration
REQ-029 Macro IBF_SCALE_EN: when defined, each Y output SHALL be its 33-bit sum arithmetically shifted right by 1, i.e. bits [32:1], giving the IFFT 1/2-per-stage normalisation with no overflow.
REQ-030 When IBF_SCALE_EN is undefined, outputs SHALL be bits [31:0] with wrap, per REQ-015; latency and handshake SHALL be identical in both builds.

Verification (unscaled build unless noted)
REQ-031 xp=(1,0), xq=(1,0), W=(1,0), i.e. all 1.0 = 0x00010000 -> after 2 cycles yp=(0x00020000,0), yq=(0,0).
REQ-032 xp=(1,0), xq=(1,0), W=(0,1) -> yp=(0x00010000,0xFFFF0000), yq=(0x00010000,0x00010000).
REQ-033 xq_real=0xFFFFFFFF, xq_imag=0, W=(0x00008000,0), xp=0 -> t_real floors to -1 LSB; yp_real=0xFFFFFFFF, yq_real=0x00000001.
REQ-034 Stream 4 sets back-to-back with out_ready=1 -> 4 results on 4 consecutive cycles, in order; then hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0, no loss after release.
REQ-035 Two sets in flight, rst_n pulsed low 1 cycle -> out_valid=0 and busy=0 immediately; neither set appears afterwards.
REQ-036 IBF_SCALE_EN build: xp=(0x7FFF0000,0), xq=(0x7FFF0000,0), W=(1,0) -> yp_real=0x7FFF0000 with no wrap; the unscaled build gives 0xFFFE0000.
